// File: rtl/hazard_stall_unit_pkg.sv
// Shared widths and defaults for the D-stage hazard/stall controller.
package hazard_stall_unit_pkg;
    localparam int DEF_AW          = 5;
    localparam int DEF_TW          = 3;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 32;
    // Tuse value for an operand the instruction never reads
    localparam int TUSE_NEVER      = 3;
endpackage

// File: rtl/md_busy_counter.sv
// MDU busy countdown: reloads on every mult/div start, otherwise counts down to 0.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;

    // a new start always restarts the countdown, even mid-operation
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (start)
            md_cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) md_cnt_q <= '0;
        else          md_cnt_q <= md_cnt_d;
    end

    assign busy = (md_cnt_q != '0);
endmodule

// File: rtl/hazard_stall_unit.sv
// Tuse/Tnew interlock plus MDU-busy interlock; drives pipeline enables, D/E flush
// and a saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int TW          = DEF_TW,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    D_rs,
    input  logic [AW-1:0]    D_rt,
    input  logic [TW-1:0]    rs_tuse,
    input  logic [TW-1:0]    rt_tuse,
    input  logic             D_md,
    input  logic [AW-1:0]    E_A3,
    input  logic [TW-1:0]    E_tnew,
    input  logic [AW-1:0]    M_A3,
    input  logic [TW-1:0]    M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_div,
    input  logic             cnt_clr,
    output logic             IFU_en,
    output logic             F2D_en,
    output logic             D2E_en,
    output logic             D2E_flush,
    output logic             E2M_en,
    output logic             M2W_en,
    output logic             stall,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    logic rs_stall, rt_stall, md_stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // a producer only blocks when its value arrives later than the consumer needs it
    always_comb begin
        rs_stall = ((rs_tuse < E_tnew) && (E_A3 != '0) && (E_A3 == D_rs)) ||
                   ((rs_tuse < M_tnew) && (M_A3 != '0) && (M_A3 == D_rs));
        rt_stall = ((rt_tuse < E_tnew) && (E_A3 != '0) && (E_A3 == D_rt)) ||
                   ((rt_tuse < M_tnew) && (M_A3 != '0) && (M_A3 == D_rt));
    end

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (E_md_start),
        .is_div  (E_md_div),
        .busy    (md_busy)
    );

    // the start cycle itself must block: the countdown is not loaded yet
    assign md_stall = D_md && (E_md_start || md_busy);
    assign stall    = rs_stall || rt_stall || md_stall;

    assign IFU_en    = ~stall;
    assign F2D_en    = ~stall;
    assign D2E_en    = ~stall;
    assign D2E_flush = stall;
    assign E2M_en    = 1'b1;
    assign M2W_en    = 1'b1;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Next-generation pipeline hazard and stall controller for the 5-stage MIPS core, sitting beside the D-stage decoder.
- Takes pre-decoded register addresses plus Tuse/Tnew values for the D, E and M stages, and produces the pipeline-register enables, the D→E flush and a global stall.
- Beyond the plain Tuse/Tnew interlock, it tracks a multi-cycle multiply/divide unit (MDU) with an internal busy countdown, stalls MDU-dependent instructions in D, and keeps a saturating stall-cycle performance counter.

Parameters:
- AW, 5, register address width.
- TW, 3, width of Tuse/Tnew values.
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E (≥1).
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E (≥MULT_CYCLES).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- D_rs  in  AW  rs address of the instruction in D.
- D_rt  in  AW  rt address of the instruction in D.
- rs_tuse  in  TW  cycles until D needs rs.
- rt_tuse  in  TW  cycles until D needs rt.
- D_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_A3  in  AW  destination register of E (0 = none).
- E_tnew  in  TW  cycles until E's result is available.
- M_A3  in  AW  destination register of M (0 = none).
- M_tnew  in  TW  cycles until M's result is available.
- E_md_start  in  1  mult/div instruction currently in E (1-cycle pulse per instruction).
- E_md_div  in  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- IFU_en  out  1  PC update enable.
- F2D_en  out  1  F/D register enable.
- D2E_en  out  1  D/E register enable.
- D2E_flush  out  1  insert bubble into D/E.
- E2M_en  out  1  E/M register enable.
- M2W_en  out  1  M/W register enable.
- stall  out  1  global stall.
- md_busy  out  1  MDU countdown non-zero.
- stall_cnt  out  CNT_W  number of stalled cycles.

Behaviour:
- Data hazard, combinational:
  - rs_stall = (rs_tuse < E_tnew && E_A3 != 0 && E_A3 == D_rs) || (rs_tuse < M_tnew && M_A3 != 0 && M_A3 == D_rs).
  - rt_stall is the same with rt_tuse and D_rt.
  - Comparisons are unsigned, TW bits.
- MDU countdown, register md_cnt of width clog2(DIV_CYCLES+1), reset 0:
  - E_md_start=1 → load DIV_CYCLES if E_md_div, else MULT_CYCLES. Load has priority over decrement, including when already busy.
  - Otherwise, md_cnt != 0 → decrement by 1.
  - md_busy = (md_cnt != 0), registered-state derived.
- md_stall = D_md && (E_md_start || md_busy). Result: an MDU instruction in D waits until the cycle after md_cnt reaches 0.
- stall = rs_stall | rt_stall | md_stall, purely combinational from inputs and state. Zero-cycle response.
- Enables:
  - IFU_en = F2D_en = D2E_en = ~stall.
  - D2E_flush = stall.
  - E2M_en = M2W_en = 1 always.
- stall_cnt:
  - cnt_clr → 0 (priority).
  - Else stall && stall_cnt != all-ones → +1.
  - Saturates at 2^CNT_W−1.
- Reset (asynchronous assert, synchronous-safe release):
  - md_cnt = 0, stall_cnt = 0, md_busy = 0.
  - All outputs are then purely a function of inputs.
  - Reset asserted mid-countdown aborts it immediately.
- Boundary conditions:
  - Register 0 never causes a stall.
  - Tnew = 0 never stalls.
  - Simultaneous E and M match: either one stalls.
  - E_md_start while D_md=1 → stall in that same cycle.
  - The flushed bubble reaching E must carry E_md_start=0. Upstream guarantees this; the block does not check it.

Decomposition:
- Shared package (const.v defines): AW, TW, default MULT_CYCLES/DIV_CYCLES, TUSE_NEVER = 3.
- One natural sub-module: md_busy_counter (load/decrement countdown with busy flag). The stall_cnt logic stays inline.

Test Plan:
- Load-use: E_A3=8, E_tnew=2, D_rs=8, rs_tuse=1 → stall=1, D2E_flush=1, IFU_en=0. Next cycle M_A3=8, M_tnew=1, rs_tuse=1 → stall=0.
- Zero register: E_A3=0, E_tnew=2, D_rs=0, rs_tuse=0 → stall=0.
- Branch vs ALU: E_A3=5, E_tnew=1, D_rt=5, rt_tuse=0 → stall=1. Same with rt_tuse=1 → stall=0.
- Divide: E_md_start=1, E_md_div=1 at cycle 0, D_md=1 held:
  - stall=1 for cycles 0–10; md_busy=1 for cycles 1–10.
  - stall=0 at cycle 11.
  - Repeat with a multiply → stall clears at cycle 6.
- Reset mid-operation: reset_n low at cycle 3 of a divide → md_busy=0 and stall_cnt=0 immediately. After release, D_md=1 → stall=0.
- Counter:
  - 7 stalled cycles → stall_cnt=7.
  - cnt_clr together with stall → 0.
  - With CNT_W=4, 20 stalled cycles → stall_cnt=15.
